// File: rtl/object_table_loader.sv
// object_table_loader: sequences the three-phase X / Y / state transfer from
// software over the to_hw_sig / to_sw_sig handshake. Fields land in a shadow
// bank, and the whole table is copied to the active bank on a frame boundary,
// so the sprite logic never sees a half-written table.
// Optional build macro OBJ_TABLE_SYNC_EN: adds a 2-flop synchronizer on
// to_hw_sig, which adds two cycles to ack and release latency.
module object_table_loader #(
  parameter int NUM_OBJ     = 10,
  parameter int Y_FLIP_BASE = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             to_hw_sig,
  input  logic [32*NUM_OBJ-1:0]  to_hw_port,
  input  logic                   frame_start,
  output logic [1:0]             to_sw_sig,
  output logic [10*NUM_OBJ-1:0]  x_coord,
  output logic [10*NUM_OBJ-1:0]  y_coord,
  output logic [3*NUM_OBJ-1:0]   obj_state,
  output logic [2:0]             type0,
  output logic                   busy,
  output logic                   commit
);

  typedef enum logic [2:0] {
    WAIT_X, ACK_X, WAIT_Y, ACK_Y, WAIT_S, ACK_S, PENDING
  } state_t;

  localparam logic [9:0] YBase = 10'(Y_FLIP_BASE);

  state_t state_q, state_d;
  logic [1:0] sig;
  logic capX, capY, capS;
  logic commit_d, busy_d;
  logic [1:0] toSwSig_d;

  logic [10*NUM_OBJ-1:0] shadowX_q, shadowX_d;
  logic [10*NUM_OBJ-1:0] shadowY_q, shadowY_d;
  logic [3*NUM_OBJ-1:0]  shadowS_q, shadowS_d;
  logic [2:0]            shadowT0_q, shadowT0_d;

  logic [10*NUM_OBJ-1:0] activeX_q, activeY_q;
  logic [3*NUM_OBJ-1:0]  activeS_q;
  logic [2:0]            activeT0_q;
  logic [1:0]            toSwSig_q;
  logic                  busy_q, commit_q;

  // Upper port bits beyond the captured fields are deliberately ignored.
  logic unusedPortBits;
  assign unusedPortBits = ^to_hw_port;

`ifdef OBJ_TABLE_SYNC_EN
  logic [1:0] sigMeta_q, sigSync_q;

  // Two-flop synchronizer on the phase code; port data is stable by protocol.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sigMeta_q <= '0;
      sigSync_q <= '0;
    end else begin
      sigMeta_q <= to_hw_sig;
      sigSync_q <= sigMeta_q;
    end
  end

  assign sig = sigSync_q;
`else
  assign sig = to_hw_sig;
`endif

  // Handshake sequencing: capture on the expected code, wait for 0, commit on frame.
  always_comb begin
    state_d  = state_q;
    capX     = 1'b0;
    capY     = 1'b0;
    capS     = 1'b0;
    commit_d = 1'b0;
    case (state_q)
      WAIT_X:  if (sig == 2'd1) begin capX = 1'b1; state_d = ACK_X; end
      ACK_X:   if (sig == 2'd0) state_d = WAIT_Y;
      WAIT_Y:  if (sig == 2'd2) begin capY = 1'b1; state_d = ACK_Y; end
      ACK_Y:   if (sig == 2'd0) state_d = WAIT_S;
      WAIT_S:  if (sig == 2'd3) begin capS = 1'b1; state_d = ACK_S; end
      ACK_S:   if (sig == 2'd0) state_d = PENDING;
      PENDING: if (frame_start) begin commit_d = 1'b1; state_d = WAIT_X; end
      default: state_d = WAIT_X;
    endcase
  end

  // Registered handshake outputs are decoded from the state being entered.
  always_comb begin
    toSwSig_d = 2'd0;
    busy_d    = 1'b0;
    case (state_d)
      ACK_X:   toSwSig_d = 2'd1;
      ACK_Y:   toSwSig_d = 2'd2;
      ACK_S:   toSwSig_d = 2'd3;
      PENDING: busy_d    = 1'b1;
      default: ;
    endcase
  end

  // Shadow bank next values; Y for slots 1..N-1 is flipped against the screen height.
  always_comb begin
    shadowX_d  = shadowX_q;
    shadowY_d  = shadowY_q;
    shadowS_d  = shadowS_q;
    shadowT0_d = shadowT0_q;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (capX) shadowX_d[10*i +: 10] = to_hw_port[32*i +: 10];
      if (capY) shadowY_d[10*i +: 10] = (i == 0) ? to_hw_port[9:0]
                                                 : YBase - to_hw_port[32*i +: 10];
      if (capS) shadowS_d[3*i +: 3] = to_hw_port[32*i +: 3];
    end
    if (capS) shadowT0_d = to_hw_port[5:3];
  end

  // State, shadow and active banks; reset discards any partial transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= WAIT_X;
      shadowX_q  <= '0;
      shadowY_q  <= '0;
      shadowS_q  <= '0;
      shadowT0_q <= '0;
      activeX_q  <= '0;
      activeY_q  <= '0;
      activeS_q  <= '0;
      activeT0_q <= '0;
      toSwSig_q  <= '0;
      busy_q     <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadowX_q  <= shadowX_d;
      shadowY_q  <= shadowY_d;
      shadowS_q  <= shadowS_d;
      shadowT0_q <= shadowT0_d;
      toSwSig_q  <= toSwSig_d;
      busy_q     <= busy_d;
      commit_q   <= commit_d;
      if (commit_d) begin
        activeX_q  <= shadowX_q;
        activeY_q  <= shadowY_q;
        activeS_q  <= shadowS_q;
        activeT0_q <= shadowT0_q;
      end
    end
  end

  assign to_sw_sig = toSwSig_q;
  assign x_coord   = activeX_q;
  assign y_coord   = activeY_q;
  assign obj_state = activeS_q;
  assign type0     = activeT0_q;
  assign busy      = busy_q;
  assign commit    = commit_q;

endmodule

// File: tb/tb_object_table_loader.sv
// Testbench for object_table_loader: directed transfers with a scoreboard.
// Stimulus pushes expected ack codes and committed tables into queues; a
// monitor pops and compares whenever to_sw_sig changes or commit pulses.
module tb_object_table_loader;

  localparam int N = 10;
`ifdef OBJ_TABLE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [10*N-1:0] x;
    logic [10*N-1:0] y;
    logic [3*N-1:0]  st;
    logic [2:0]      t0;
  } tbl_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      toHwSig;
  logic [32*N-1:0] toHwPort;
  logic            frameStart;
  logic [1:0]      to_sw_sig;
  logic [10*N-1:0] x_coord, y_coord;
  logic [3*N-1:0]  obj_state;
  logic [2:0]      type0;
  logic            busy, commit;

  tbl_t       expTbl[$];
  logic [1:0] expAck[$];
  int         total = 0;
  int         bad = 0;
  logic [1:0] prevAck = 2'd0;
  logic [1:0] expA;
  tbl_t       expT, gotT;
  tbl_t       e1, e3;
  logic [32*N-1:0] xp, yp, sp;

  object_table_loader #(.NUM_OBJ(N), .Y_FLIP_BASE(480)) dut (
    .clk(clk), .reset(reset), .to_hw_sig(toHwSig), .to_hw_port(toHwPort),
    .frame_start(frameStart), .to_sw_sig(to_sw_sig), .x_coord(x_coord),
    .y_coord(y_coord), .obj_state(obj_state), .type0(type0),
    .busy(busy), .commit(commit)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every ack change and every commit pulse pops an expectation.
  always @(negedge clk) begin
    if (to_sw_sig !== prevAck) begin
      total++;
      if (expAck.size() == 0) begin
        bad++;
        $display("[TB] FAIL ackEvent: got %0d expected no change", to_sw_sig);
      end else begin
        expA = expAck.pop_front();
        if (to_sw_sig !== expA) begin
          bad++;
          $display("[TB] FAIL ackEvent: got %0d expected %0d", to_sw_sig, expA);
        end
      end
      prevAck = to_sw_sig;
    end
    if (commit === 1'b1) begin
      total++;
      gotT = '{x: x_coord, y: y_coord, st: obj_state, t0: type0};
      if (expTbl.size() == 0) begin
        bad++;
        $display("[TB] FAIL commitEvent: got unexpected commit expected none");
      end else begin
        expT = expTbl.pop_front();
        if (gotT !== expT) begin
          bad++;
          $display("[TB] FAIL commitTable: got x=%0h y=%0h st=%0h t0=%0h expected x=%0h y=%0h st=%0h t0=%0h",
                   gotT.x, gotT.y, gotT.st, gotT.t0, expT.x, expT.y, expT.st, expT.t0);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [32*N-1:0] fillAll(input logic [31:0] v);
    logic [32*N-1:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  function automatic logic [32*N-1:0] junk();
    logic [32*N-1:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Raise a phase code, wait (bounded) for its ack, then hold with changing port data.
  task automatic applyStimulus(input logic [1:0] code, input logic [32*N-1:0] port, input int hold);
    int cyc = 0;
    bit found = 0;
    toHwSig  = code;
    toHwPort = port;
    expAck.push_back(code);
    while (!found && cyc < 8) begin
      stepCycle();
      cyc++;
      if (to_sw_sig === code) found = 1;
    end
    checkOutput("ackLatency", cyc, LAT);
    for (int h = 0; h < hold; h++) begin
      toHwPort = junk();
      stepCycle();
      checkOutput("ackHold", to_sw_sig, code);
    end
  endtask

  // Drop the code to 0 and wait for release; optionally pulse frame_start on the PENDING-entry edge.
  task automatic releaseCode(input bit fs);
    int cyc = 0;
    bit found = 0;
    toHwSig = 2'd0;
    expAck.push_back(2'd0);
    while (!found && cyc < 8) begin
      frameStart = fs && (cyc == LAT - 1);
      stepCycle();
      frameStart = 1'b0;
      cyc++;
      if (to_sw_sig === 2'd0) found = 1;
    end
    checkOutput("releaseLatency", cyc, LAT);
  endtask

  // An unexpected code must produce no ack (the monitor also flags any change).
  task automatic outOfOrder(input logic [1:0] code);
    toHwSig  = code;
    toHwPort = fillAll(32'h0000_03FF);
    repeat (3) begin
      stepCycle();
      checkOutput("orderNoAck", to_sw_sig, 2'd0);
    end
    toHwSig = 2'd0;
    repeat (LAT) stepCycle();
  endtask

  task automatic doCommit(input tbl_t exp);
    expTbl.push_back(exp);
    frameStart = 1'b1;
    stepCycle();
    frameStart = 1'b0;
    checkOutput("commitPulse", commit, 1'b1);
    stepCycle();
    checkOutput("commitDrop", commit, 1'b0);
    checkOutput("busyClear", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; toHwSig = 2'd0; toHwPort = '0; frameStart = 1'b0;
    repeat (2) stepCycle();
    checkOutput("resetAck", to_sw_sig, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetCommit", commit, 0);
    checkOutput("resetX", x_coord, 0);
    checkOutput("resetY", y_coord, 0);
    checkOutput("resetState", obj_state, 0);
    checkOutput("resetType0", type0, 0);
    reset = 1'b1;
    stepCycle();

    // First table: X=100+i, Y=10*i (flipped), state=i, with hand overrides.
    for (int i = 0; i < N; i++) begin
      xp[32*i +: 32]    = 32'(100 + i);
      e1.x[10*i +: 10]  = 10'(100 + i);
      yp[32*i +: 32]    = 32'(10 * i);
      e1.y[10*i +: 10]  = 10'(480 - 10 * i);
      sp[32*i +: 32]    = 32'hABCD_0000 | 32'(i);
      e1.st[3*i +: 3]   = 3'(i);
    end
    yp[31:0]  = 32'h2D;  e1.y[9:0]   = 10'd45;
    yp[63:32] = 32'd30;  e1.y[19:10] = 10'd450;
    yp[95:64] = 32'd500; e1.y[29:20] = 10'd1004;
    sp[31:0]  = 32'h2D;  e1.st[2:0]  = 3'd5;
    e1.t0 = 3'd5;

    outOfOrder(2'd2);
    outOfOrder(2'd3);
    applyStimulus(2'd1, xp, 20);
    releaseCode(1'b0);
    frameStart = 1'b1;
    stepCycle();
    frameStart = 1'b0;
    repeat (2) stepCycle();
    checkOutput("noCommitWaitY", commit, 0);
    outOfOrder(2'd1);
    outOfOrder(2'd3);
    applyStimulus(2'd2, yp, 2);
    releaseCode(1'b0);
    outOfOrder(2'd1);
    outOfOrder(2'd2);
    applyStimulus(2'd3, sp, 2);
    releaseCode(1'b1);
    repeat (3) stepCycle();
    checkOutput("pendingBusy", busy, 1);
    checkOutput("pendingX", x_coord, 0);
    checkOutput("pendingY", y_coord, 0);
    checkOutput("pendingState", obj_state, 0);
    checkOutput("pendingType0", type0, 0);
    toHwSig = 2'd1;
    repeat (3) stepCycle();
    checkOutput("pendingNoAck", to_sw_sig, 0);
    toHwSig = 2'd0;
    repeat (LAT) stepCycle();
    doCommit(e1);
    checkOutput("x1", x_coord[19:10], 101);
    checkOutput("y0", y_coord[9:0], 45);
    checkOutput("y1", y_coord[19:10], 450);
    checkOutput("y2Wrap", y_coord[29:20], 1004);
    checkOutput("state0", obj_state[2:0], 5);
    checkOutput("type0", type0, 5);

    // Aborted transfer: reset while acking Y clears everything.
    applyStimulus(2'd1, fillAll(32'd200), 0);
    releaseCode(1'b0);
    applyStimulus(2'd2, fillAll(32'd77), 0);
    expAck.push_back(2'd0);
    reset = 1'b0;
    toHwSig = 2'd0;
    stepCycle();
    checkOutput("midResetAck", to_sw_sig, 0);
    checkOutput("midResetX", x_coord, 0);
    checkOutput("midResetY", y_coord, 0);
    checkOutput("midResetState", obj_state, 0);
    checkOutput("midResetType0", type0, 0);
    checkOutput("midResetBusy", busy, 0);
    reset = 1'b1;
    stepCycle();

    // Third table after reset starts again from the X phase.
    for (int i = 0; i < N; i++) begin
      xp[32*i +: 32]    = 32'(300 + i);
      e3.x[10*i +: 10]  = 10'(300 + i);
      yp[32*i +: 32]    = 32'(7 * i);
      e3.y[10*i +: 10]  = 10'(480 - 7 * i);
      sp[32*i +: 32]    = 32'(i + 2);
      e3.st[3*i +: 3]   = 3'(i + 2);
    end
    e3.y[9:0] = 10'd0;
    sp[31:0]  = 32'h3B; e3.st[2:0] = 3'd3;
    e3.t0 = 3'd7;
    applyStimulus(2'd1, xp, 1);
    releaseCode(1'b0);
    applyStimulus(2'd2, yp, 1);
    releaseCode(1'b0);
    applyStimulus(2'd3, sp, 1);
    releaseCode(1'b0);
    stepCycle();
    checkOutput("pendingBusy2", busy, 1);
    doCommit(e3);

    repeat (2) stepCycle();
    checkOutput("ackQueueEmpty", expAck.size(), 0);
    checkOutput("tblQueueEmpty", expTbl.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/object_table_loader.md
# object_table_loader

Synchronous controller that sequences the three-phase software-to-hardware object-table transfer (X coordinates, Y coordinates, state/type) over the PIO handshake pair `to_hw_sig`/`to_sw_sig`. Captured fields go into a shadow bank. The complete table is committed to the active bank only on a frame boundary, so the sprite renderer never sees a half-updated table. Sits between the NIOS PIO ports and the sprite/draw logic, replacing latch-based capture with registered, ordered, double-buffered capture.

## Interface
- `NUM_OBJ`, 10, number of object slots transferred per table.
- `Y_FLIP_BASE`, 480, screen height used to flip Y for objects 1..NUM_OBJ-1.
- `clk  in  1`: system clock; all state is updated on its rising edge.
- `reset  in  1`: synchronous, active-low reset.
- `to_hw_sig  in  2`: phase code from software. 0 = idle, 1 = X, 2 = Y, 3 = state/type.
- `to_hw_port  in  32*NUM_OBJ`: PIO data. Slot i is bits [32i+31:32i].
- `frame_start  in  1`: one-cycle pulse at the start of vertical blank.
- `to_sw_sig  out  2`: acknowledge code returned to software.
- `x_coord  out  10*NUM_OBJ`: active X for each slot.
- `y_coord  out  10*NUM_OBJ`: active Y for each slot.
- `obj_state  out  3*NUM_OBJ`: active state for each slot.
- `type0  out  3`: active type of object 0.
- `busy  out  1`: 1 while a table is pending commit.
- `commit  out  1`: one-cycle pulse when the shadow bank is copied to the active bank.

## Operation
- FSM states: `WAIT_X`, `ACK_X`, `WAIT_Y`, `ACK_Y`, `WAIT_S`, `ACK_S`, `PENDING`.
- `WAIT_X`: on `sig==1`, capture shadow X[i] = port_i[9:0] for every slot, then go to `ACK_X`.
- `WAIT_Y`: on `sig==2`, capture shadow Y, then go to `ACK_Y`.
  - Slot 0: Y[0] = port_0[9:0], stored raw.
  - Slots 1..N-1: Y[i] = (Y_FLIP_BASE - port_i[9:0]), truncated to 10 bits (mod 1024).
- `WAIT_S`: on `sig==3`, capture shadow state[i] = port_i[2:0] and type0 = port_0[5:3], then go to `ACK_S`.
- `ACK_n`: drive `to_sw_sig = n`. Hold until `sig==0`, then advance to the next WAIT state; `ACK_S` advances to `PENDING`. Any nonzero `sig` while in `ACK_n` leaves the state unchanged.
- Out-of-order codes in a WAIT state (any nonzero value other than the expected one) are ignored: no capture, no ack, no state change.
- `PENDING`: `busy=1`, `to_sw_sig=0`, all `sig` values ignored. On `frame_start`, copy the shadow bank to the active bank, pulse `commit`, and go to `WAIT_X`.
- `frame_start` in any state other than `PENDING` has no effect.
- The active bank changes only on commit. The shadow bank changes only on a capture.

## Timing
- On reset (`reset==0` at an edge), the following are all 0: every active output, every shadow register, `to_sw_sig`, `busy`, `commit`. The FSM enters `WAIT_X`.
- Reset mid-transfer discards any partially captured shadow data.
- All outputs are registered.
- Ack latency: if the expected code is sampled at edge k, the capture happens at edge k and `to_sw_sig` is valid after edge k, i.e. one cycle.
- Ack release: if `sig==0` is sampled at edge k in `ACK_n`, `to_sw_sig==0` after edge k.
- Commit: if `frame_start` is sampled at edge k in `PENDING`, the active outputs update and `commit=1` after edge k. `commit` drops after edge k+1.
- If `frame_start` coincides with the `ACK_S` to `PENDING` transition, it is not consumed; commit waits for the next frame.
- Software may keep `to_hw_port` changing outside the capture edge. Only the capture edge matters.

## Configuration
- `OBJ_TABLE_SYNC_EN` defined: `to_hw_sig` passes through a 2-flop synchronizer (reset to 0) before the FSM. This adds 2 cycles to ack and release latency. Port data is not synchronized; it is stable by protocol.
- `OBJ_TABLE_SYNC_EN` undefined: `to_hw_sig` feeds the FSM directly, with the 1-cycle latencies given above.

## Test plan
- Full transfer, default parameters: X ports = 100+i; sig 1 → 0 → 2 → 0 → 3 → 0; port1 Y = 30; port0 = 0x2D.
  - Before any frame_start, active outputs are still 0 and `busy=1`.
  - After frame_start: x_coord[1]=101, y_coord[1]=450, y_coord[0] = port0[9:0], state0=5, type0=5, and `commit` pulses once.
- Wrap: port2 Y = 500 → y_coord[2] = (480-500) mod 1024 = 1004.
- Ordering: sig=2 or sig=3 in `WAIT_X` → `to_sw_sig` stays 0 and the shadow is unchanged. A following sig=1 is then acked normally.
- Handshake hold: sig held at 1 for 20 cycles → `to_sw_sig=1` throughout with no further capture (port changes during the hold are ignored). Dropping to 0 releases the ack the next cycle.
- Frame gating: frame_start pulses while in `WAIT_Y` → no commit. Frame_start on the same cycle the FSM enters `PENDING` → no commit; the next frame_start commits.
- Reset: active-low reset asserted in `ACK_Y` with a committed table present → all outputs 0 after one edge. The subsequent transfer starts from `WAIT_X`.
